// File: rtl/matrix_capture.sv
// matrix_capture: double-buffered capture of a sync-aligned byte scan stream, read out at host pace.
// Optional MATRIX_CAPTURE_STATS_EN adds the saturating sync-error and dropped-frame counters.
module matrix_capture #(
  parameter int ADDR_DEPTH = 4,
  parameter int MAX_ADDR   = 2**ADDR_DEPTH-1
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       scan_sync,
  input  logic [7:0] scan_data,
  input  logic       read_strobe,
  output logic [7:0] rpi_data,
  output logic       rd_first,
  output logic       locked,
  output logic       frame_valid,
  output logic [7:0] error_count,
  output logic [7:0] drop_count
);

  localparam logic [ADDR_DEPTH-1:0] LAST_ADDR = ADDR_DEPTH'(MAX_ADDR);

  typedef enum logic {HUNT = 1'b0, CAPTURE = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_DEPTH-1:0] cnt_reg, cnt_next;
  logic [ADDR_DEPTH-1:0] rd_ptr_reg;
  logic                  front_sel_reg;
  logic                  locked_reg;
  logic                  frame_valid_reg;
  logic [7:0]            rpi_data_reg;
  logic                  strobe_meta_reg, strobe_sync_reg, strobe_prev_reg;
  logic                  strobe_edge;
  logic                  wr_en, sync_err, lock_set, frame_done, commit;
  logic [ADDR_DEPTH-1:0] wr_addr;

  // Both buffers share one array; the top address bit selects the bank.
  logic [7:0] buf_mem [0:2**(ADDR_DEPTH+1)-1];

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (scan_sync) begin
      state_next = CAPTURE;
      cnt_next   = ADDR_DEPTH'(1);
    end else if (state_reg == CAPTURE) begin
      if (cnt_reg == '0)
        state_next = HUNT;
      else if (cnt_reg == LAST_ADDR)
        cnt_next = '0;
      else
        cnt_next = cnt_reg + 1'b1;
    end
  end

  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = cnt_reg;
    sync_err   = 1'b0;
    lock_set   = 1'b0;
    frame_done = 1'b0;
    if (scan_sync) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      if (state_reg == CAPTURE) begin
        sync_err = (cnt_reg != '0);
        lock_set = (cnt_reg == '0);
      end
    end else if (state_reg == CAPTURE) begin
      if (cnt_reg == '0) begin
        sync_err = 1'b1;
      end else begin
        wr_en      = 1'b1;
        frame_done = (cnt_reg == LAST_ADDR);
      end
    end
  end

  // A frame is handed to the host only while it sits at word 0 and is not moving.
  assign commit = frame_done && (rd_ptr_reg == '0) && !strobe_edge;

  always_ff @(posedge clk_100mhz) begin
    if (wr_en)
      buf_mem[{~front_sel_reg, wr_addr}] <= scan_data;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      strobe_meta_reg <= 1'b0;
      strobe_sync_reg <= 1'b0;
      strobe_prev_reg <= 1'b0;
    end else begin
      strobe_meta_reg <= read_strobe;
      strobe_sync_reg <= strobe_meta_reg;
      strobe_prev_reg <= strobe_sync_reg;
    end
  end

  assign strobe_edge = strobe_sync_reg & ~strobe_prev_reg;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg      <= '0;
      front_sel_reg   <= 1'b0;
      frame_valid_reg <= 1'b0;
      locked_reg      <= 1'b0;
    end else begin
      if (strobe_edge)
        rd_ptr_reg <= (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + 1'b1;
      if (commit) begin
        front_sel_reg   <= ~front_sel_reg;
        frame_valid_reg <= 1'b1;
      end
      if (sync_err)
        locked_reg <= 1'b0;
      else if (lock_set)
        locked_reg <= 1'b1;
    end
  end

  // Buffers hold power-up garbage, so the host sees zero until a frame is committed.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)
      rpi_data_reg <= 8'h00;
    else
      rpi_data_reg <= frame_valid_reg ? buf_mem[{front_sel_reg, rd_ptr_reg}] : 8'h00;
  end

  assign rpi_data    = rpi_data_reg;
  assign rd_first    = (rd_ptr_reg == '0);
  assign locked      = locked_reg;
  assign frame_valid = frame_valid_reg;

`ifdef MATRIX_CAPTURE_STATS_EN
  logic [7:0] error_count_reg, drop_count_reg;
  logic       drop_event;

  assign drop_event = frame_done & ~commit;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      error_count_reg <= 8'h00;
      drop_count_reg  <= 8'h00;
    end else begin
      if (sync_err && error_count_reg != 8'hFF)
        error_count_reg <= error_count_reg + 8'h01;
      if (drop_event && drop_count_reg != 8'hFF)
        drop_count_reg <= drop_count_reg + 8'h01;
    end
  end

  assign error_count = error_count_reg;
  assign drop_count  = drop_count_reg;
`else
  assign error_count = 8'h00;
  assign drop_count  = 8'h00;
`endif

endmodule

// File: tb/tb_matrix_capture.sv
// tb_matrix_capture: randomized scan/read stimulus, frame-level reference model, queued scoreboard.
// Counter expectations follow MATRIX_CAPTURE_STATS_EN the same way the design does.
module tb_matrix_capture;
  localparam int N = 16;

  logic       clk_100mhz = 1'b0;
  logic       rst_n;
  logic       scan_sync;
  logic [7:0] scan_data;
  logic       read_strobe;
  logic [7:0] rpi_data;
  logic       rd_first;
  logic       locked;
  logic       frame_valid;
  logic [7:0] error_count;
  logic [7:0] drop_count;

  always #5 clk_100mhz = ~clk_100mhz;

  matrix_capture #(.ADDR_DEPTH(4)) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .scan_sync  (scan_sync),
    .scan_data  (scan_data),
    .read_strobe(read_strobe),
    .rpi_data   (rpi_data),
    .rd_first   (rd_first),
    .locked     (locked),
    .frame_valid(frame_valid),
    .error_count(error_count),
    .drop_count (drop_count)
  );

  typedef struct {
    int         due;
    bit         async_chk;
    bit         chk_rpi;
    int         kind;
    logic [7:0] rpi;
    bit         first;
    bit         lck;
    bit         fv;
    logic [7:0] err;
    logic [7:0] drop;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, async_e, left_e;
  int   pos_cnt  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: committed frame contents plus the partial frame being collected.
  bit         m_hunt, m_fv, m_locked;
  logic [7:0] m_cur[$];
  logic [7:0] m_front[N];
  int         m_rd_ptr, m_err, m_drop;

  function automatic string kind_name(input int k);
    case (k)
      0: return "reset";
      1: return "mid_frame";
      2: return "after_frames";
      3: return "read";
      4: return "async_reset";
      default: return "after_reset";
    endcase
  endfunction

  function automatic void model_reset();
    m_hunt   = 1'b1;
    m_cur.delete();
    m_fv     = 1'b0;
    m_locked = 1'b0;
    m_rd_ptr = 0;
    m_err    = 0;
    m_drop   = 0;
  endfunction

  function automatic void bump_err();
    m_err    = (m_err < 255) ? m_err + 1 : 255;
    m_locked = 1'b0;
  endfunction

  function automatic void model_step(input bit s, input logic [7:0] d);
    if (m_hunt) begin
      if (s) begin
        m_cur  = {d};
        m_hunt = 1'b0;
      end
    end else if (s) begin
      if (m_cur.size() != 0) bump_err();
      else m_locked = 1'b1;
      m_cur = {d};
    end else if (m_cur.size() == 0) begin
      bump_err();
      m_hunt = 1'b1;
    end else begin
      m_cur.push_back(d);
      if (m_cur.size() == N) begin
        if (m_rd_ptr == 0) begin
          for (int i = 0; i < N; i++) m_front[i] = m_cur[i];
          m_fv = 1'b1;
        end else begin
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        m_cur.delete();
      end
    end
  endfunction

  task automatic push_check(input int kind, input bit chk_rpi, input bit async_chk);
    exp_t e;
    e.due       = pos_cnt + 1;
    e.async_chk = async_chk;
    e.chk_rpi   = chk_rpi;
    e.kind      = kind;
    e.rpi       = m_fv ? m_front[m_rd_ptr] : 8'h00;
    e.first     = (m_rd_ptr == 0);
    e.lck       = m_locked;
    e.fv        = m_fv;
`ifdef MATRIX_CAPTURE_STATS_EN
    e.err       = 8'(m_err);
    e.drop      = 8'(m_drop);
`else
    e.err       = 8'h00;
    e.drop      = 8'h00;
`endif
    exp_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    bit ok;
    ok = (rd_first === e.first) && (locked === e.lck) && (frame_valid === e.fv) &&
         (error_count === e.err) && (drop_count === e.drop) &&
         (!e.chk_rpi || (rpi_data === e.rpi));
    n_checks++;
    if (ok) begin
      n_pass++;
      $display("check %0d %s cyc %0d: rpi=%02h first=%b locked=%b valid=%b err=%0d drop=%0d ok",
               n_checks, kind_name(e.kind), pos_cnt, rpi_data, rd_first, locked, frame_valid,
               error_count, drop_count);
    end else begin
      $display("FAIL %s cyc %0d: got rpi=%02h first=%b locked=%b valid=%b err=%0d drop=%0d, expected rpi=%02h(%s) first=%b locked=%b valid=%b err=%0d drop=%0d",
               kind_name(e.kind), pos_cnt, rpi_data, rd_first, locked, frame_valid, error_count,
               drop_count, e.rpi, e.chk_rpi ? "checked" : "ignored", e.first, e.lck, e.fv,
               e.err, e.drop);
    end
  endtask

  always @(posedge clk_100mhz) pos_cnt <= pos_cnt + 1;

  // Monitor: compares each queued expectation once its observation cycle arrives.
  always @(negedge clk_100mhz) begin
    while (exp_q.size() > 0 && !exp_q[0].async_chk && exp_q[0].due <= pos_cnt) begin
      mon_e = exp_q.pop_front();
      compare(mon_e);
    end
  end

  always @(negedge rst_n) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].async_chk) begin
      async_e = exp_q.pop_front();
      compare(async_e);
    end
  end

  task automatic step(input bit s, input logic [7:0] d, input bit strb);
    @(negedge clk_100mhz);
    scan_sync   = s;
    scan_data   = d;
    read_strobe = strb;
    model_step(s, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic send_frame(input int nw, input bit idx_data);
    for (int w = 0; w < nw; w++) begin
      step(w == 0, idx_data ? 8'(w) : 8'($urandom_range(0, 255)), 1'b0);
      if (w == 8) push_check(1, 1'b0, 1'b0);
    end
  endtask

  task automatic end_stream();
    idle(3);
    push_check(2, 1'b1, 1'b0);
  endtask

  task automatic strobe_read();
    step(1'b0, 8'($urandom_range(0, 255)), 1'b1);
    step(1'b0, 8'($urandom_range(0, 255)), 1'b1);
    m_rd_ptr = (m_rd_ptr + 1) % N;
    idle(8);
    push_check(3, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_100mhz);
    #2;
    model_reset();
    push_check(4, 1'b1, 1'b1);
    rst_n       = 1'b0;
    scan_sync   = 1'b0;
    read_strobe = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;
    push_check(5, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    scan_sync   = 1'b0;
    scan_data   = 8'h00;
    read_strobe = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_100mhz);
    push_check(0, 1'b1, 1'b0);
    @(negedge clk_100mhz);
    rst_n = 1'b1;

    // Indexed frames, then a full walk of the read pointer.
    repeat (3) send_frame(N, 1'b1);
    end_stream();
    repeat (N) strobe_read();

    // Early sync, recovery, relock.
    send_frame(10, 1'b0);
    repeat (3) send_frame(N, 1'b0);
    end_stream();

    // Host parked mid-frame: completions are dropped.
    repeat (5) strobe_read();
    repeat (2) send_frame(N, 1'b0);
    end_stream();
    repeat (N - 5) strobe_read();

    // Reset in the middle of a frame, then capture resumes.
    send_frame(7, 1'b0);
    do_reset();
    repeat (2) send_frame(N, 1'b0);
    end_stream();

    for (int t = 0; t < 30; t++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        int nf;
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
          if ($urandom_range(0, 3) == 0) send_frame($urandom_range(1, N - 1), 1'b0);
          send_frame(N, 1'b0);
        end
        end_stream();
      end else if (op <= 8) begin
        int k;
        k = $urandom_range(1, 6);
        repeat (k) strobe_read();
      end else begin
        send_frame($urandom_range(1, N - 1), 1'b0);
        do_reset();
      end
    end

    repeat (4) @(negedge clk_100mhz);
    while (exp_q.size() > 0) begin
      left_e = exp_q.pop_front();
      n_checks++;
      $display("FAIL %s never observed: got no sample, expected due cycle %0d",
               kind_name(left_e.kind), left_e.due);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
